// File: rtl/reg_file_dual_wr_pkg.sv
// Shared constants and types for the dual-write integer register file.
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

endpackage : regfile_pkg

// File: rtl/reg_file_dual_wr_if.sv
// Core-side bus of the register file: two read ports, two write ports,
// scoreboard issue port and status outputs.
interface reg_file_dual_wr_if #(
  parameter int XLEN  = regfile_pkg::XLEN,
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
);

  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;

  logic            we0;
  logic [AW-1:0]   waddr0;
  logic [XLEN-1:0] wdata0;
  logic            we1;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata1;

  logic            pend_set;
  logic [AW-1:0]   pend_addr;

  logic            busy1;
  logic            busy2;
  logic            wr_conflict;

  // Core side: issues reads, writes and scoreboard marks.
  modport master (
    output rs1, rs2, we0, waddr0, wdata0, we1, waddr1, wdata1, pend_set, pend_addr,
    input  rdata1, rdata2, busy1, busy2, wr_conflict
  );

  // Register file side.
  modport slave (
    input  rs1, rs2, we0, waddr0, wdata0, we1, waddr1, wdata1, pend_set, pend_addr,
    output rdata1, rdata2, busy1, busy2, wr_conflict
  );

endinterface : reg_file_dual_wr_if

// File: rtl/reg_file_dual_wr_scoreboard.sv
// Per-register pending bits: set on issue of a long-latency op, cleared by
// a writeback (port 0) to the same register. Register 0 is never pending.
module reg_scoreboard #(
  parameter int NREGS = regfile_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy1,
  output logic          busy2
);

  logic [NREGS-1:0] pending;

  // Pending bit update; a set in the same cycle as a clear wins because a
  // new producer has just been issued for that register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments here; the later statement to the same bit wins, which is what gives set priority over clear.
      if (clr_en && (clr_addr != '0)) pending[clr_addr] <= 1'b0;
      if (set_en && (set_addr != '0)) pending[set_addr] <= 1'b1;
    end
  end

  // Busy lookup straight from state; no bypass of a same-cycle set.
  always_comb begin
    busy1 = pending[rs1] && (rs1 != '0);
    busy2 = pending[rs2] && (rs2 != '0);
  end

endmodule : reg_scoreboard

// File: rtl/reg_file_dual_wr.sv
// Integer register file with two prioritised write ports (port 0 wins),
// optional write-to-read bypass, and a pending scoreboard for stalls.
module reg_file_dual_wr #(
  parameter int XLEN   = regfile_pkg::XLEN,
  parameter int NREGS  = regfile_pkg::NREGS,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_file_dual_wr_if.slave bus
);

  logic [XLEN-1:0] regs [NREGS];

  logic we0_eff;
  logic we1_eff;
  logic conflict;
  logic busy1_w;
  logic busy2_w;

  // Effective write enables: x0 is hard-wired, port 1 yields to port 0 on the same address.
  always_comb begin
    we0_eff  = bus.we0 && (bus.waddr0 != '0);
    conflict = we0_eff && bus.we1 && (bus.waddr1 == bus.waddr0);
    we1_eff  = bus.we1 && (bus.waddr1 != '0) && !conflict;
  end

  // Register storage; reset clears every architectural register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the whole array is reset on purpose, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we0_eff) regs[bus.waddr0] <= bus.wdata0;
      if (we1_eff) regs[bus.waddr1] <= bus.wdata1;
    end
  end

  // Flag a dropped port-1 write for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.wr_conflict <= 1'b0;
    else        bus.wr_conflict <= conflict;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = regs[addr];
    if (BYPASS != 0) begin
      if (we1_eff && (bus.waddr1 == addr)) val = bus.wdata1;
      if (we0_eff && (bus.waddr0 == addr)) val = bus.wdata0;
    end
    if (addr == '0) val = '0;
    return val;
  endfunction

  // Combinational read ports with optional same-cycle bypass, port 0 first.
  always_comb begin
    // NOTE: every output of this block is assigned on every path, so no latch is inferred.
    bus.rdata1 = read_port(bus.rs1);
    bus.rdata2 = read_port(bus.rs2);
  end

  reg_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (bus.pend_set),
    .set_addr (bus.pend_addr),
    .clr_en   (bus.we0),
    .clr_addr (bus.waddr0),
    .rs1      (bus.rs1),
    .rs2      (bus.rs2),
    .busy1    (busy1_w),
    .busy2    (busy2_w)
  );

  // Scoreboard status onto the bus.
  always_comb begin
    bus.busy1 = busy1_w;
    bus.busy2 = busy2_w;
  end

endmodule : reg_file_dual_wr

// File: tb/tb_reg_file_dual_wr.sv
// Bench for reg_file_dual_wr: one BYPASS=1 and one BYPASS=0 instance share
// the same stimulus and are compared every cycle against an array model.
module tb_reg_file_dual_wr;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus
  logic      we0, we1, pend_set;
  reg_addr_t waddr0, waddr1, pend_addr, rs1, rs2;
  xlen_t     wdata0, wdata1;

  reg_file_dual_wr_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_b1 ();
  reg_file_dual_wr_if #(.XLEN(XLEN), .NREGS(NREGS)) bus_b0 ();

  assign bus_b1.rs1 = rs1;          assign bus_b0.rs1 = rs1;
  assign bus_b1.rs2 = rs2;          assign bus_b0.rs2 = rs2;
  assign bus_b1.we0 = we0;          assign bus_b0.we0 = we0;
  assign bus_b1.waddr0 = waddr0;    assign bus_b0.waddr0 = waddr0;
  assign bus_b1.wdata0 = wdata0;    assign bus_b0.wdata0 = wdata0;
  assign bus_b1.we1 = we1;          assign bus_b0.we1 = we1;
  assign bus_b1.waddr1 = waddr1;    assign bus_b0.waddr1 = waddr1;
  assign bus_b1.wdata1 = wdata1;    assign bus_b0.wdata1 = wdata1;
  assign bus_b1.pend_set = pend_set;   assign bus_b0.pend_set = pend_set;
  assign bus_b1.pend_addr = pend_addr; assign bus_b0.pend_addr = pend_addr;

  reg_file_dual_wr #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b1.slave));
  reg_file_dual_wr #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst_n(rst_n), .bus(bus_b0.slave));

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  xlen_t m_regs [NREGS];
  bit    m_pend [NREGS];
  bit    m_conf;

  // Architectural state after each clock: port 0 beats port 1, writeback
  // retires a pending mark unless a new mark is issued the same cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
      m_conf = 1'b0;
    end else begin
      m_conf = we0 && we1 && (waddr0 == waddr1) && (waddr0 != 0);
      if (we1 && waddr1 != 0 && !m_conf) m_regs[waddr1] = wdata1;
      if (we0 && waddr0 != 0) m_regs[waddr0] = wdata0;
      if (we0 && waddr0 != 0) m_pend[waddr0] = 1'b0;
      if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    end
  end

  function automatic xlen_t exp_rd(input int addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && we0 && int'(waddr0) == addr) return wdata0;
    if (byp && we1 && int'(waddr1) == addr) return wdata1;
    return m_regs[addr];
  endfunction

  function automatic logic [31:0] exp_busy(input int addr);
    return {31'b0, (addr != 0) && m_pend[addr]};
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("b1.rdata1", bus_b1.rdata1, exp_rd(rs1, 1'b1));
      check("b1.rdata2", bus_b1.rdata2, exp_rd(rs2, 1'b1));
      check("b0.rdata1", bus_b0.rdata1, exp_rd(rs1, 1'b0));
      check("b0.rdata2", bus_b0.rdata2, exp_rd(rs2, 1'b0));
      check("b1.busy1", {31'b0, bus_b1.busy1}, exp_busy(rs1));
      check("b1.busy2", {31'b0, bus_b1.busy2}, exp_busy(rs2));
      check("b0.busy1", {31'b0, bus_b0.busy1}, exp_busy(rs1));
      check("b1.wr_conflict", {31'b0, bus_b1.wr_conflict}, {31'b0, m_conf});
      check("b0.wr_conflict", {31'b0, bus_b0.wr_conflict}, {31'b0, m_conf});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_idle();
    we0 = 0; waddr0 = '0; wdata0 = '0;
    we1 = 0; waddr1 = '0; wdata1 = '0;
    pend_set = 0; pend_addr = '0;
  endtask

  // Drive one cycle's inputs just after the edge, return at the mid-cycle sample point.
  task automatic step(input bit w0, input int a0, input logic [31:0] d0,
                      input bit w1, input int a1, input logic [31:0] d1,
                      input bit ps, input int pa, input int r1, input int r2);
    @(posedge clk); #1;
    we0 = w0; waddr0 = reg_addr_t'(a0); wdata0 = d0;
    we1 = w1; waddr1 = reg_addr_t'(a1); wdata1 = d1;
    pend_set = ps; pend_addr = reg_addr_t'(pa);
    rs1 = reg_addr_t'(r1); rs2 = reg_addr_t'(r2);
    @(negedge clk);
  endtask

  task automatic idle(input int r1, input int r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  task automatic rand_step();
    // Narrow address range half the time so collisions are frequent.
    int lim;
    lim = ($urandom_range(0, 1) == 0) ? 3 : NREGS - 1;
    step($urandom_range(0, 1), $urandom_range(0, lim), $urandom,
         $urandom_range(0, 1), $urandom_range(0, lim), $urandom,
         ($urandom_range(0, 3) == 0), $urandom_range(0, lim),
         $urandom_range(0, lim), $urandom_range(0, lim));
  endtask

  initial begin
    set_idle();
    rs1 = '0; rs2 = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_en = 1'b1;

    // Reset state
    idle(1, 31);
    check("reset rdata1", bus_b1.rdata1, 32'h0);
    check("reset rdata2", bus_b1.rdata2, 32'h0);
    check("reset conflict", {31'b0, bus_b1.wr_conflict}, 32'h0);

    // x0 ignores writes, also on the bypass path
    step(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    check("x0 same-cycle b1", bus_b1.rdata1, 32'h0);
    idle(0, 0);
    check("x0 next cycle", bus_b1.rdata1, 32'h0);

    // Dual write to distinct registers
    step(1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0, 0);
    idle(5, 6);
    check("dual x5", bus_b0.rdata1, 32'h11);
    check("dual x6", bus_b0.rdata2, 32'h22);
    check("dual no conflict", {31'b0, bus_b1.wr_conflict}, 32'h0);

    // Dual write to the same register: port 0 wins, one-cycle flag
    step(1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 0, 0);
    idle(7, 0);
    check("same-addr x7", bus_b0.rdata1, 32'hAA);
    check("conflict high", {31'b0, bus_b0.wr_conflict}, 32'h1);
    idle(7, 0);
    check("conflict low", {31'b0, bus_b0.wr_conflict}, 32'h0);

    // Bypass vs stored value
    step(1, 3, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 3, 32'h99, 0, 0, 0, 0, 0, 3, 0);
    check("bypass on", bus_b1.rdata1, 32'h99);
    check("bypass off", bus_b0.rdata1, 32'h1);
    step(1, 3, 32'h5, 1, 3, 32'h6, 0, 0, 0, 3);
    check("bypass both ports", bus_b1.rdata2, 32'h5);

    // Scoreboard
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    check("busy not bypassed", {31'b0, bus_b1.busy1}, 32'h0);
    step(1, 9, 32'h5, 0, 0, 0, 1, 9, 9, 0);
    check("busy after set", {31'b0, bus_b1.busy1}, 32'h1);
    idle(9, 0);
    check("set beats clear", {31'b0, bus_b1.busy1}, 32'h1);
    step(1, 9, 32'h6, 0, 0, 0, 0, 0, 9, 0);
    idle(9, 0);
    check("cleared by we0", {31'b0, bus_b1.busy1}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 9, 32'h7, 0, 0, 9, 0);
    idle(9, 9);
    check("we1 keeps busy", {31'b0, bus_b1.busy1}, 32'h1);
    check("we1 still writes", bus_b0.rdata2, 32'h7);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(0, 0);
    check("x0 never busy", {31'b0, bus_b1.busy1}, 32'h0);

    // Randomised traffic with a reset landing in the middle
    for (int c = 0; c < 300; c++) rand_step();
    @(posedge clk); #1 rst_n = 1'b0;
    for (int c = 0; c < 2; c++) rand_step();
    @(posedge clk); #3 rst_n = 1'b1;
    for (int c = 0; c < 300; c++) rand_step();

    // Mid-run reset with a write in flight: everything clears, write lost
    step(1, 4, 32'h77, 1, 8, 32'h88, 1, 4, 0, 0);
    rst_n = 1'b0;
    set_idle();
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(4, 8);
    check("reset drops write", bus_b1.rdata1, 32'h0);
    check("reset drops pend", {31'b0, bus_b1.busy1}, 32'h0);
    for (int r = 0; r < NREGS; r += 2) begin
      idle(r, r + 1);
      check("post-reset rdata1", bus_b1.rdata1, 32'h0);
      check("post-reset rdata2", bus_b1.rdata2, 32'h0);
      check("post-reset busy2", {31'b0, bus_b1.busy2}, 32'h0);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_reg_file_dual_wr
